// File: rtl/seq_det_pkg.sv
// Shared types and default sizes for the serial pattern detector.
package seq_det_pkg;

   localparam int DEF_PAT_WIDTH = 4;
   localparam int DEF_CNT_WIDTH = 8;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      ARMED   = 2'd2
   } seq_state_t;

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial bit stream, pattern load and match status bundle.
interface seq_detector_param_if
   import seq_det_pkg::*;
#(
   parameter int PAT_WIDTH = DEF_PAT_WIDTH,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
   logic                 bit_in;
   logic                 bit_valid;
   logic                 load;
   logic [PAT_WIDTH-1:0] pat_in;
   logic                 overlap;
   logic                 out;
   logic [CNT_WIDTH-1:0] match_count;
   logic                 armed;

   modport master (
      output bit_in, bit_valid, load, pat_in, overlap,
      input  out, match_count, armed
   );

   modport slave (
      input  bit_in, bit_valid, load, pat_in, overlap,
      output out, match_count, armed
   );
endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);
   logic [CNT_WIDTH-1:0] count_d, count_q;

   // next count: step on inc unless already saturated
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   // count register, clear dominates
   always_ff @(posedge clk) begin
      if (clr) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime-loadable pattern.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   EMPTY   | no valid bits in history (after reset/load/non-overlap match)
//   FILLING | 0 < fill < PAT_WIDTH
//   ARMED   | history holds PAT_WIDTH valid bits
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int                   PAT_WIDTH = DEF_PAT_WIDTH,
   parameter int                   CNT_WIDTH = DEF_CNT_WIDTH,
   parameter logic [PAT_WIDTH-1:0] RESET_PAT = 4'b1011
) (
   input logic                 clk,
   input logic                 reset,
   seq_detector_param_if.slave bus
);
   localparam int             FW        = $clog2(PAT_WIDTH + 1);
   localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_WIDTH);

   seq_state_t           state_d, state_q;
   logic [PAT_WIDTH-1:0] pat_d, pat_q;
   logic [PAT_WIDTH-1:0] hist_d, hist_q;
   logic [FW-1:0]        fill_d, fill_q;
   logic                 out_d, out_q;
   logic                 armed_d, armed_q;

   logic                 shift_en;
   logic [PAT_WIDTH-1:0] window;
   logic [FW-1:0]        fill_inc;
   logic                 match;

   // load beats a same-cycle valid bit, so the bit never enters history
   assign shift_en = bus.bit_valid && !bus.load;
   assign window   = {hist_q[PAT_WIDTH-2:0], bus.bit_in};
   assign fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
   assign match    = shift_en && (window == pat_q) && (fill_inc == FILL_FULL);

   // next-state: history, fill, pattern and FSM state
   always_comb begin
      pat_d  = pat_q;
      hist_d = hist_q;
      fill_d = fill_q;
      out_d  = 1'b0;
      if (bus.load) begin
         pat_d  = bus.pat_in;
         hist_d = '0;
         fill_d = '0;
      end else if (shift_en) begin
         hist_d = window;
         fill_d = fill_inc;
         if (match) begin
            out_d = 1'b1;
            if (!bus.overlap) begin
               hist_d = '0;
               fill_d = '0;
            end
         end
      end

      if (fill_d == '0) begin
         state_d = EMPTY;
      end else if (fill_d == FILL_FULL) begin
         state_d = ARMED;
      end else begin
         state_d = FILLING;
      end
      armed_d = (state_d == ARMED);
   end

   // all detector registers; reset overrides load and valid bits
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         pat_q   <= RESET_PAT;
         hist_q  <= '0;
         fill_q  <= '0;
         out_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         out_q   <= out_d;
         armed_q <= armed_d;
      end
   end

   sat_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_match_cnt (
      .clk   (clk),
      .clr   (reset),
      .inc   (match),
      .count (bus.match_count)
   );

   assign bus.out   = out_q;
   assign bus.armed = armed_q;
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector. It compares a stream of qualified serial bits against a runtime-loadable pattern of PAT_WIDTH bits and emits a one-cycle registered match pulse. Overlapping and non-overlapping detection are selectable, and a saturating match counter is included. It is the general replacement for the fixed-pattern serial FSM detectors in the design and sits directly on any single-bit serial input path.

## Interface
- PAT_WIDTH, 4: pattern length in bits; legal range 2..32.
- CNT_WIDTH, 8: width of the match counter.
- RESET_PAT, 4'b1011: pattern value held after reset; PAT_WIDTH bits wide.
- clk  input  1  single clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  qualifies bit_in; ignored cycles do not shift history.
- load  input  1  latch pat_in as the new pattern; clears history.
- pat_in  input  PAT_WIDTH  new pattern. The MSB is the first bit expected in time.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every valid bit.
- out  output  1  match pulse, one cycle wide.
- match_count  output  CNT_WIDTH  number of matches since reset; saturates at all-ones.
- armed  output  1  history holds at least PAT_WIDTH valid bits.

## Operation
- History: PAT_WIDTH-bit shift register `hist`. On a valid bit: hist <= {hist[PAT_WIDTH-2:0], bit_in}. The newest bit is the LSB.
- Fill counter `fill` (0..PAT_WIDTH, saturating) tracks how many valid bits are in hist.
- FSM states:
  - EMPTY (fill=0).
  - FILLING (0<fill<PAT_WIDTH).
  - ARMED (fill=PAT_WIDTH).
- FSM transitions:
  - EMPTY→FILLING on a valid bit.
  - FILLING→ARMED when fill reaches PAT_WIDTH.
  - Any state→EMPTY on load or reset.
  - ARMED→EMPTY on a match when overlap=0.
- Match condition, evaluated on the cycle of a valid bit: the post-shift window equals the pattern register, and fill (including this bit) is ≥ PAT_WIDTH.
- On a match:
  - out is set to 1 for the next cycle.
  - match_count increments unless it is all-ones.
  - overlap=0: fill and hist clear to 0, so the next match needs PAT_WIDTH fresh bits.
  - overlap=1: history is kept, so the next match can reuse trailing bits.
- Load:
  - Pattern register <= pat_in; hist and fill clear; state goes to EMPTY.
  - match_count is kept.
  - If bit_valid is also high, load wins and the bit is discarded.
- Reset: pattern <= RESET_PAT; hist, fill, out, match_count clear; state goes to EMPTY.
- armed = (state == ARMED), registered.

## Timing
- Reset values: out=0, match_count=0, armed=0, pattern=RESET_PAT.
- Latency: the valid bit completing the pattern, sampled at edge N, gives out=1 after edge N; it is held for exactly one cycle. match_count updates on the same edge.
- Back-to-back matches (overlap=1, pattern of all-ones): out stays high on consecutive valid cycles.
- bit_valid low: no shift, and out drops at the next edge.
- Reset mid-stream takes effect at the next edge and overrides load and bit_valid.
- A pattern change applies only to bits after the load edge.
- Changing overlap mid-stream has no effect on stored history; it governs the post-match action only.

## Structure
- Shared package seq_det_pkg holds:
  - FSM state enum (EMPTY, FILLING, ARMED).
  - Default PAT_WIDTH and CNT_WIDTH constants.
- Optional sub-module sat_counter (CNT_WIDTH, synchronous clear and increment) for match_count. All other logic is flat in seq_detector_param.

## Test plan
- Overlap: reset, PAT=1011, overlap=1, valid stream 1,0,1,1,0,1,1 → out pulses the cycle after bit 4 and bit 7; match_count=2.
- Non-overlap: same stream, overlap=0 → one pulse after bit 4; bits 5–7 do not match; match_count=1, armed=0 after bit 4.
- Gaps: stream 1,0 with bit_valid low for 3 cycles, then 1,1 → single pulse after the final 1; no shift during gaps.
- Load: load pat_in=0110 while bit_valid=1 with bit 1 → bit discarded; then stream 0,1,1,0 → pulse once; earlier matches are retained in match_count.
- Saturation: CNT_WIDTH=2, PAT=1111, overlap=1, stream of 8 ones → match_count stops at 3; out is high on every cycle from bit 4 onward.
- Mid-stream reset: reset asserted after bits 1,0,1, then stream 1,0,1,1 → pattern=RESET_PAT, no false match on the first bit after reset, pulse after the 4th bit, match_count=1.
